// File: rtl/reset_responder.sv
// reset_responder: downstream end of the staged reset handshake for one subsystem.
// Define AUTO_RETRY_EN to re-run a timed-out sequence up to MAXRETRY times before error.
module reset_responder #(
  parameter int RLW      = 16,
  parameter int TOW      = 32,
  parameter int RCW      = 8,
  parameter int MAXRETRY = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           resetreq,
  input  logic [RLW-1:0] rstlength,
  input  logic [RLW-1:0] stablelength,
  input  logic [TOW-1:0] timeout,
  input  logic           status,
  output logic           subrst,
  output logic           ready,
  output logic           done,
  output logic           donestrobe,
  output logic           error,
  output logic           lostlock,
  output logic [RCW-1:0] losscount,
  output logic [RCW-1:0] retrycount
);

  typedef enum logic [2:0] {IDLE, HOLD, SETTLE, DONE, ERROR} state_t;

  state_t         state, state_next;
  logic           stat_meta, stat_s, stat_prev;
  logic [RLW-1:0] rl_eff, sl_eff, sl_cap, hold_cnt, stab_cnt, stab_next;
  logic [TOW-1:0] to_cap, to_cnt;
  logic [RCW-1:0] loss_cnt;
  logic           lost, strobe;
  logic           stab_hit, to_hit, retry_go, loss_edge;
`ifdef AUTO_RETRY_EN
  logic [RLW-1:0] rl_cap;
  logic [RCW-1:0] retry_cnt;
`endif

  assign rl_eff = (rstlength == '0) ? RLW'(1) : rstlength;
  assign sl_eff = (stablelength == '0) ? RLW'(1) : stablelength;

  // A new request overrides everything; stability completion beats a same-cycle timeout.
  always_comb begin
    stab_next = stat_s ? stab_cnt + RLW'(1) : '0;
    stab_hit  = (state == SETTLE) && (stab_next == sl_cap);
    to_hit    = ((state == HOLD) || (state == SETTLE)) && (to_cap != '0)
                && ((to_cnt + TOW'(1)) == to_cap);
    loss_edge = (state == DONE) && stat_prev && !stat_s;
    retry_go  = 1'b0;
`ifdef AUTO_RETRY_EN
    retry_go  = to_hit && !stab_hit && (retry_cnt < RCW'(MAXRETRY));
`endif
    state_next = state;
    case (state)
      HOLD:    if (hold_cnt <= RLW'(1)) state_next = SETTLE;
      SETTLE:  if (stab_hit) state_next = DONE;
      default: ;
    endcase
    if (to_hit && !stab_hit) state_next = retry_go ? HOLD : ERROR;
    if (resetreq) state_next = HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stat_meta <= 1'b0;
      stat_s    <= 1'b0;
      stat_prev <= 1'b0;
      strobe    <= 1'b0;
      lost      <= 1'b0;
      loss_cnt  <= '0;
      sl_cap    <= '0;
      hold_cnt  <= '0;
      stab_cnt  <= '0;
      to_cap    <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_next;
      stat_meta <= status;
      stat_s    <= stat_meta;
      stat_prev <= stat_s;
      strobe    <= (state == SETTLE) && (state_next == DONE);
      if (loss_edge) begin
        lost <= 1'b1;
        if (loss_cnt != '1) loss_cnt <= loss_cnt + RCW'(1);
      end
      // Sequence lengths are captured once per request so later input changes are ignored.
      if (resetreq) begin
        hold_cnt <= rl_eff;
        sl_cap   <= sl_eff;
        to_cap   <= timeout;
        to_cnt   <= '0;
        stab_cnt <= '0;
        lost     <= 1'b0;
      end
`ifdef AUTO_RETRY_EN
      else if (retry_go) begin
        hold_cnt <= rl_cap;
        to_cnt   <= '0;
        stab_cnt <= '0;
      end
`endif
      else begin
        if (state == HOLD) hold_cnt <= hold_cnt - RLW'(1);
        if ((state == HOLD) || (state == SETTLE)) to_cnt <= to_cnt + TOW'(1);
        stab_cnt <= (state == SETTLE) ? stab_next : '0;
      end
    end
  end

`ifdef AUTO_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rl_cap    <= '0;
      retry_cnt <= '0;
    end else if (resetreq) begin
      rl_cap    <= rl_eff;
      retry_cnt <= '0;
    end else if (retry_go) begin
      retry_cnt <= retry_cnt + RCW'(1);
    end
  end
  assign retrycount = retry_cnt;
`else
  assign retrycount = '0;
`endif

  assign subrst     = (state == HOLD);
  assign done       = (state == DONE);
  assign ready      = done && stat_s;
  assign donestrobe = strobe;
  assign error      = (state == ERROR);
  assign lostlock   = lost;
  assign losscount  = loss_cnt;

endmodule

// File: tb/tb_reset_responder.sv
// tb_reset_responder: table-driven and randomized checks of reset_responder against a
// window-level model of the handshake timing.
module tb_reset_responder;

  localparam int MAXR = 3;
  localparam int NMAX = 1024;

  typedef struct packed {
    logic       subrst, ready, done, strobe, error, lostlock;
    logic [7:0] loss, retry;
  } out_t;

  typedef struct {
    int rl, sl, to, rise, glitch, d1, d1n, d2, d2n, len, req2;
    int exp_strobe, exp_nstrobe, exp_err, exp_loss;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0, resetreq = 1'b0, status = 1'b0;
  logic [15:0] rstlength = '0, stablelength = '0;
  logic [31:0] timeout = '0;
  logic        subrst, ready, done, donestrobe, error, lostlock;
  logic [7:0]  losscount, retrycount;

  bit   pin  [0:NMAX-1];
  out_t expv [0:NMAX-1];
  int   total = 0, bad = 0;
  int   first_strobe, n_strobe, first_err, last_loss;
  vec_t tbl [9];

  reset_responder #(.RLW(16), .TOW(32), .RCW(8), .MAXRETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .resetreq(resetreq), .rstlength(rstlength),
    .stablelength(stablelength), .timeout(timeout), .status(status),
    .subrst(subrst), .ready(ready), .done(done), .donestrobe(donestrobe),
    .error(error), .lostlock(lostlock), .losscount(losscount), .retrycount(retrycount)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit ss(input int k);
    return (k >= 2) ? pin[k-2] : 1'b0;
  endfunction

  // Expected outputs for cycles t0+1..len given a request in cycle t0.
  function automatic void model(input int t0, r, s, tmo, len, base, output int done_c);
    int   starts[$];
    int   a, c, run, tend, err_c, loss, e;
    bit   lost;
    out_t o;
    r = (r == 0) ? 1 : r;
    s = (s == 0) ? 1 : s;
    a = t0 + 1; done_c = -1; err_c = -1;
    starts.push_back(a);
    forever begin
      c = -1; run = 0;
      for (int k = a + r; k <= len; k++) begin
        run = ss(k) ? run + 1 : 0;
        if (run == s) begin c = k + 1; break; end
      end
      tend = (tmo == 0) ? len + NMAX : a + tmo;
      if (c != -1 && c <= tend) begin done_c = c; break; end
      if (tend > len) break;
`ifdef AUTO_RETRY_EN
      if (starts.size() <= MAXR) begin a = tend; starts.push_back(a); continue; end
`endif
      err_c = tend;
      break;
    end
    loss = base; lost = 1'b0;
    for (int k = t0 + 1; k <= len; k++) begin
      o = '0;
      for (int i = 0; i < starts.size(); i++) begin
        e = (i + 1 < starts.size()) ? starts[i+1] : ((err_c >= 0) ? err_c : len + 1);
        if (k >= starts[i] && k < starts[i] + r && k < e) o.subrst = 1'b1;
        if (k >= starts[i]) o.retry = 8'(i);
      end
      if (done_c >= 0 && k >= done_c) begin
        o.done   = 1'b1;
        o.ready  = ss(k);
        o.strobe = (k == done_c);
        if (k > done_c && ss(k-2) && !ss(k-1)) begin
          lost = 1'b1;
          if (loss < 255) loss++;
        end
      end
      o.error    = (err_c >= 0 && k >= err_c);
      o.lostlock = lost;
      o.loss     = 8'(loss);
      expv[k]    = o;
    end
  endfunction

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_output(input int idx, input int k);
    out_t got;
    got = {subrst, ready, done, donestrobe, error, lostlock, losscount, retrycount};
    total++;
    if (got !== expv[k]) begin
      bad++;
      $display("[TB] FAIL outputs case=%0d cycle=%0d got=%h want=%h", idx, k, got, expv[k]);
    end
    if (donestrobe === 1'b1) begin
      n_strobe++;
      if (first_strobe < 0) first_strobe = k;
    end
    if (error === 1'b1 && first_err < 0) first_err = k;
    last_loss = int'(losscount);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; resetreq = 1'b0; status = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    int dc, base;
    expv[0] = '0;
    model(0, v.rl, v.sl, v.to, v.len, 0, dc);
    if (v.req2 >= 0) begin
      base = int'(expv[v.req2].loss)
             + ((dc >= 0 && v.req2 >= dc && ss(v.req2 - 1) && !ss(v.req2)) ? 1 : 0);
      model(v.req2, v.rl, v.sl, v.to, v.len, base, dc);
    end
    first_strobe = -1; n_strobe = 0; first_err = -1; last_loss = 0;
    do_reset();
    for (int k = 0; k <= v.len; k++) begin
      resetreq     = (k == 0 || k == v.req2);
      status       = pin[k];
      rstlength    = resetreq ? 16'(v.rl) : 16'($urandom);
      stablelength = resetreq ? 16'(v.sl) : 16'($urandom);
      timeout      = resetreq ? 32'(v.to) : $urandom;
      @(negedge clk);
      check_output(idx, k);
      @(posedge clk); #1;
    end
    resetreq = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   lvl, n, k;
    tbl[0] = '{10, 20, 1000, 50, -1, -1, 0, -1, 0, 100, -1, 72, 1, -1, 0};
    tbl[1] = '{10, 20, 1000, 20, 35, -1, 0, -1, 0, 100, -1, 58, 1, -1, 0};
    tbl[3] = '{5, 10, 0, 10, -1, 40, 5, 60, 3, 90, -1, 22, 1, -1, 2};
    tbl[4] = '{0, 0, 0, 0, -1, -1, 0, -1, 0, 20, -1, 3, 1, -1, 0};
    tbl[5] = '{4, 10, 14, 0, -1, -1, 0, -1, 0, 60, -1, 15, 1, -1, 0};
    tbl[7] = '{10, 20, 1000, 50, -1, -1, 0, -1, 0, 120, 71, 102, 1, -1, 0};
`ifdef AUTO_RETRY_EN
    tbl[2] = '{10, 20, 100, -1, -1, -1, 0, -1, 0, 420, 410, -1, 0, 401, 0};
    tbl[6] = '{4, 10, 13, 0, -1, -1, 0, -1, 0, 60, -1, -1, 0, 53, 0};
    tbl[8] = '{10, 20, 60, 70, -1, -1, 0, -1, 0, 130, -1, 92, 1, -1, 0};
`else
    tbl[2] = '{10, 20, 100, -1, -1, -1, 0, -1, 0, 130, 110, -1, 0, 101, 0};
    tbl[6] = '{4, 10, 13, 0, -1, -1, 0, -1, 0, 60, -1, -1, 0, 14, 0};
    tbl[8] = '{10, 20, 60, 70, -1, -1, 0, -1, 0, 130, -1, -1, 0, 61, 0};
`endif

    for (int i = 0; i < 9; i++) begin
      v = tbl[i];
      for (int j = 0; j < NMAX; j++) begin
        pin[j] = (v.rise >= 0 && j >= v.rise);
        if (j == v.glitch) pin[j] = 1'b0;
        if (v.d1 >= 0 && j >= v.d1 && j < v.d1 + v.d1n) pin[j] = 1'b0;
        if (v.d2 >= 0 && j >= v.d2 && j < v.d2 + v.d2n) pin[j] = 1'b0;
      end
      apply_stimulus(v, i);
      check_int($sformatf("first_strobe[%0d]", i), first_strobe, v.exp_strobe);
      check_int($sformatf("n_strobe[%0d]", i), n_strobe, v.exp_nstrobe);
      check_int($sformatf("first_error[%0d]", i), first_err, v.exp_err);
      check_int($sformatf("losscount[%0d]", i), last_loss, v.exp_loss);
    end

    for (int r = 0; r < 10; r++) begin
      v = '{0, 0, 0, -1, -1, -1, 0, -1, 0, 160, -1, -1, 0, -1, 0};
      v.rl   = int'($urandom_range(0, 12));
      v.sl   = int'($urandom_range(0, 15));
      v.to   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(10, 90));
      v.req2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 140)) : -1;
      lvl = 0; k = 0;
      while (k < NMAX) begin
        n = lvl ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 20));
        for (int j = 0; j < n && k < NMAX; j++) begin
          pin[k] = lvl[0];
          k++;
        end
        lvl = 1 - lvl;
      end
      apply_stimulus(v, 100 + r);
    end

    // Reset in the middle of HOLD must clear everything on the following cycle.
    do_reset();
    resetreq = 1'b1; rstlength = 16'd10; stablelength = 16'd5; timeout = 32'd0; status = 1'b1;
    @(posedge clk); #1;
    resetreq = 1'b0;
    @(negedge clk);
    check_int("hold_subrst", int'(subrst), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_int("hold_before_rst", int'(subrst), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("rst_subrst", int'(subrst), 0);
    check_int("rst_outputs", int'({ready, done, donestrobe, error, lostlock, losscount, retrycount}), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_int("rst_stays_idle", int'({subrst, done, error}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
